// File: rtl/envelope_detector_if.sv
// Sample/envelope bundle for envelope_detector.
// sample_valid qualifies wave_in with no backpressure; env_valid is a one-cycle pulse per new envelope.
interface envelope_detector_if;
    logic       sample_valid;
    logic [7:0] wave_in;
    logic [7:0] envelope;
    logic       env_valid;
    logic [2:0] phase;
    logic [7:0] phase_windows;
    logic [7:0] note_count;

    modport master (
        output sample_valid, wave_in,
        input  envelope, env_valid, phase, phase_windows, note_count
    );

    modport slave (
        input  sample_valid, wave_in,
        output envelope, env_valid, phase, phase_windows, note_count
    );
endinterface

// File: rtl/envelope_detector.sv
// Windowed peak envelope follower with an ADSR phase classifier.
// Optional macro ENV_SMOOTH_EN averages each new peak with the previous envelope.
module envelope_detector #(
    parameter int WINDOW_LOG2 = 8,
    parameter int DELTA       = 1
) (
    input  logic clk,
    input  logic reset,
    envelope_detector_if.slave bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ATTACK  = 3'd1,
        DECAY   = 3'd2,
        SUSTAIN = 3'd3,
        RELEASE = 3'd4
    } phase_e;

    localparam logic [8:0]             DELTA9 = 9'(DELTA);
    localparam logic [WINDOW_LOG2-1:0] LAST   = '1;

    logic [WINDOW_LOG2-1:0] r_count;
    logic [7:0]             r_peak;
    logic [7:0]             r_envelope;
    logic                   r_env_valid;
    phase_e                 r_phase;
    logic [7:0]             r_phase_windows;
    logic [7:0]             r_note_count;

    phase_e     w_next_phase;
    logic       w_note_done;
    logic       w_close;
    logic       w_rise;
    logic       w_fall;
    logic [7:0] w_peak_final;
    logic [7:0] w_n;
    logic [8:0] w_n9;
    logic [8:0] w_p9;

    assign w_close      = bus.sample_valid && (r_count == LAST);
    assign w_peak_final = (bus.wave_in > r_peak) ? bus.wave_in : r_peak;

`ifdef ENV_SMOOTH_EN
    logic [8:0] w_sum;
    assign w_sum = {1'b0, r_envelope} + {1'b0, w_peak_final} + 9'd1;
    assign w_n   = w_sum[8:1];
`else
    assign w_n = w_peak_final;
`endif

    // 9-bit compares so P+DELTA and N+DELTA cannot wrap.
    assign w_n9   = {1'b0, w_n};
    assign w_p9   = {1'b0, r_envelope};
    assign w_rise = w_n9 > (w_p9 + DELTA9);
    assign w_fall = (w_n9 + DELTA9) < w_p9;

    always_comb begin
        w_next_phase = r_phase;
        w_note_done  = 1'b0;
        if (w_close) begin
            case (r_phase)
                IDLE: begin
                    if (w_n9 > DELTA9) w_next_phase = ATTACK;
                end
                ATTACK: begin
                    if (w_rise)      w_next_phase = ATTACK;
                    else if (w_fall) w_next_phase = DECAY;
                    else             w_next_phase = SUSTAIN;
                end
                DECAY: begin
                    if (w_fall)      w_next_phase = DECAY;
                    else if (w_rise) w_next_phase = ATTACK;
                    else             w_next_phase = SUSTAIN;
                end
                SUSTAIN: begin
                    if (w_rise)      w_next_phase = ATTACK;
                    else if (w_fall) w_next_phase = RELEASE;
                    else             w_next_phase = SUSTAIN;
                end
                RELEASE: begin
                    if (w_n9 <= DELTA9) begin
                        w_next_phase = IDLE;
                        w_note_done  = 1'b1;
                    end else if (w_rise) begin
                        w_next_phase = ATTACK;
                    end
                end
                default: w_next_phase = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count         <= '0;
            r_peak          <= '0;
            r_envelope      <= '0;
            r_env_valid     <= 1'b0;
            r_phase         <= IDLE;
            r_phase_windows <= '0;
            r_note_count    <= '0;
        end else begin
            r_env_valid <= w_close;
            if (w_close) begin
                r_count    <= '0;
                r_peak     <= '0;
                r_envelope <= w_n;
                r_phase    <= w_next_phase;
                if (w_next_phase != r_phase)
                    r_phase_windows <= '0;
                else if (r_phase_windows != 8'hFF)
                    r_phase_windows <= r_phase_windows + 8'd1;
                if (w_note_done)
                    r_note_count <= r_note_count + 8'd1;
            end else if (bus.sample_valid) begin
                r_count <= r_count + 1'b1;
                r_peak  <= w_peak_final;
            end
        end
    end

    assign bus.envelope      = r_envelope;
    assign bus.env_valid     = r_env_valid;
    assign bus.phase         = r_phase;
    assign bus.phase_windows = r_phase_windows;
    assign bus.note_count    = r_note_count;

endmodule
